// File: rtl/fir_alu_pkg.sv
// Shared opcode encoding for the FIR multiply-accumulate ALU.
package fir_alu_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_MUL  = 2'b01;
  localparam op_t OP_MAC  = 2'b10;
  localparam op_t OP_MACL = 2'b11;

endpackage

// File: rtl/fir_mac_alu_if.sv
// Operand/result handshake bus between fetch logic, the MAC ALU and the FIR output register.
interface fir_mac_alu_if
  import fir_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) ();

  logic                     in_valid;
  logic                     in_ready;
  op_t                      op;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out;
  logic                     acc_ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, acc_ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, acc_ovf
  );

endinterface

// File: rtl/fir_sat_add.sv
// W-bit signed adder with overflow detect and optional clamp to full scale.
module fir_sat_add #(
  parameter int W   = 40,
  parameter bit SAT = 1'b1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] result,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum    = {a[W-1], a} + {b[W-1], b};
    ovf    = sum[W] != sum[W-1];
    result = sum[W-1:0];
    // Overflow only happens when both addends share a sign, so b's sign picks the rail.
    if (SAT && ovf) begin
      result = b[W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/fir_mac_alu.sv
// Two-stage pipelined ADD/MUL/MAC/MACL unit; stage 1 computes, stage 2 owns the accumulator.
module fir_mac_alu
  import fir_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter bit SAT    = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  fir_mac_alu_if.slave bus
);

  if (ACC_W < 2*DATA_W+1) begin : g_width_check
    $error("fir_mac_alu: ACC_W must be at least 2*DATA_W+1");
  end

  logic                     adv1, adv2;
  logic                     s1_valid;
  op_t                      s1_op;
  logic signed [ACC_W-1:0]  s1_res;
  logic signed [ACC_W-1:0]  s1_next;
  logic signed [DATA_W:0]   add_w;
  logic signed [2*DATA_W-1:0] mul_w;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_q;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  mac_res;
  logic                     mac_ovf;

  assign adv2         = !out_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = out_valid;
  assign bus.out      = out_q;
  assign bus.acc_ovf  = acc_ovf;

  always_comb begin
    add_w   = {bus.a[DATA_W-1], bus.a} + {bus.b[DATA_W-1], bus.b};
    mul_w   = (2*DATA_W)'(bus.a) * (2*DATA_W)'(bus.b);
    s1_next = (bus.op == OP_ADD) ? ACC_W'(add_w) : ACC_W'(mul_w);
  end

  fir_sat_add #(.W(ACC_W), .SAT(SAT)) u_acc_add (
    .a      (acc),
    .b      (s1_res),
    .result (mac_res),
    .ovf    (mac_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so both stages see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so out and acc read zero after reset.
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_res    <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op  <= bus.op;
          s1_res <= s1_next;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          unique case (s1_op)
            OP_MAC: begin
              acc   <= mac_res;
              out_q <= mac_res;
              if (mac_ovf) acc_ovf <= 1'b1;
            end
            OP_MACL: begin
              acc     <= s1_res;
              out_q   <= s1_res;
              acc_ovf <= 1'b0;
            end
            default: out_q <= s1_res;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_alu.sv
// Bench for fir_mac_alu: saturating and wrapping instances share stimulus, outputs scoreboarded.
module tb_fir_mac_alu;
  import fir_alu_pkg::*;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam longint MAXV  = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV  = -(longint'(1) <<< (ACC_W-1));
  localparam longint WRAPV = longint'(1) <<< ACC_W;

  logic clk;
  logic rst_n;

  fir_mac_alu_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus_s ();
  fir_mac_alu_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus_w ();

  assign bus_w.in_valid  = bus_s.in_valid;
  assign bus_w.op        = bus_s.op;
  assign bus_w.a         = bus_s.a;
  assign bus_w.b         = bus_s.b;
  assign bus_w.out_ready = bus_s.out_ready;

  fir_mac_alu #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(1'b1)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  fir_mac_alu #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(1'b0)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] out_s;
    logic             ovf_s;
    logic [ACC_W-1:0] out_w;
    logic             ovf_w;
    string            tag;
  } exp_t;

  typedef struct {
    op_t                      op;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic [ACC_W-1:0]         exp_out;
    logic                     exp_ovf;
    string                    name;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [ACC_W-1:0] last_s, last_w;
  logic             last_ovf_s, last_ovf_w;

  longint m_acc_s = 0, m_acc_w = 0;
  bit     m_ovf_s = 1'b0, m_ovf_w = 1'b0;

  vec_t vecs[12];
  logic signed [DATA_W-1:0] bp_a[7];
  logic signed [DATA_W-1:0] bp_b[7];

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers, one accumulator per SAT flavour.
  task automatic model(input op_t op, input logic signed [DATA_W-1:0] a,
                       input logic signed [DATA_W-1:0] b,
                       output longint rs, output longint rw);
    longint p, sum;
    if (op == OP_ADD) p = longint'(a) + longint'(b);
    else              p = longint'(a) * longint'(b);
    rs = p;
    rw = p;
    case (op)
      OP_MAC: begin
        sum = m_acc_s + p;
        if (sum > MAXV)      begin m_acc_s = MAXV; m_ovf_s = 1'b1; end
        else if (sum < MINV) begin m_acc_s = MINV; m_ovf_s = 1'b1; end
        else                 m_acc_s = sum;
        sum = m_acc_w + p;
        if (sum > MAXV)      begin sum = sum - WRAPV; m_ovf_w = 1'b1; end
        else if (sum < MINV) begin sum = sum + WRAPV; m_ovf_w = 1'b1; end
        m_acc_w = sum;
        rs = m_acc_s;
        rw = m_acc_w;
      end
      OP_MACL: begin
        m_acc_s = p;
        m_acc_w = p;
        m_ovf_s = 1'b0;
        m_ovf_w = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic issue(input op_t op, input logic signed [DATA_W-1:0] a,
                       input logic signed [DATA_W-1:0] b, input bit hand,
                       input logic [ACC_W-1:0] hout, input logic hovf, input string tag);
    bit     ok = 1'b0;
    longint rs, rw;
    exp_t   e;
    bus_s.in_valid = 1'b1;
    bus_s.op       = op;
    bus_s.a        = a;
    bus_s.b        = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus_s.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check({tag, "_accept_timeout"}, 0, 1);
      bus_s.in_valid = 1'b0;
    end else begin
      model(op, a, b, rs, rw);
      e.tag = tag;
      if (hand) begin
        e.out_s = hout; e.out_w = hout; e.ovf_s = hovf; e.ovf_w = hovf;
      end else begin
        e.out_s = ACC_W'(rs); e.out_w = ACC_W'(rw); e.ovf_s = m_ovf_s; e.ovf_w = m_ovf_w;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus_s.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check({tag, "_drain_timeout"}, ACC_W'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Output transfers are decided mid-cycle: out_ready only changes just after a rising edge.
  always @(negedge clk) begin
    if (rst_n && bus_s.out_valid && bus_s.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.tag, "_out"},      bus_s.out,       mon_e.out_s);
        check({mon_e.tag, "_ovf"},      bus_s.acc_ovf,   mon_e.ovf_s);
        check({mon_e.tag, "_wrap_vld"}, bus_w.out_valid, 1);
        check({mon_e.tag, "_wrap_out"}, bus_w.out,       mon_e.out_w);
        check({mon_e.tag, "_wrap_ovf"}, bus_w.acc_ovf,   mon_e.ovf_w);
      end
      last_s     = bus_s.out;
      last_w     = bus_w.out;
      last_ovf_s = bus_s.acc_ovf;
      last_ovf_w = bus_w.acc_ovf;
      n_out++;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    vecs[0]  = '{OP_ADD,  16'sh7FFF, 16'sh0001, 40'h00_0000_8000, 1'b0, "add_max_p1"};
    vecs[1]  = '{OP_ADD,  16'sh8000, 16'sh8000, 40'hFF_FFFF_0000, 1'b0, "add_min_min"};
    vecs[2]  = '{OP_MUL,  -16'sd3,   16'sd7,    40'hFF_FFFF_FFEB, 1'b0, "mul_neg"};
    vecs[3]  = '{OP_MUL,  16'sh8000, 16'sh8000, 40'h00_4000_0000, 1'b0, "mul_min_min"};
    vecs[4]  = '{OP_MACL, 16'sd2,    16'sd3,    40'h00_0000_0006, 1'b0, "macl_2x3"};
    vecs[5]  = '{OP_MAC,  16'sd4,    16'sd5,    40'h00_0000_001A, 1'b0, "mac_4x5"};
    vecs[6]  = '{OP_MAC,  -16'sd1,   16'sd10,   40'h00_0000_0010, 1'b0, "mac_m1x10"};
    vecs[7]  = '{OP_MUL,  16'sd100,  16'sd100,  40'h00_0000_2710, 1'b0, "mul_mid"};
    vecs[8]  = '{OP_MAC,  16'sd1,    16'sd1,    40'h00_0000_0011, 1'b0, "mac_after_mul"};
    vecs[9]  = '{OP_ADD,  -16'sd1,   -16'sd1,   40'hFF_FFFF_FFFE, 1'b0, "add_m1_m1"};
    vecs[10] = '{OP_MACL, -16'sd2,   16'sh7FFF, 40'hFF_FFFF_0002, 1'b0, "macl_neg"};
    vecs[11] = '{OP_MAC,  -16'sd1,   -16'sd1,   40'hFF_FFFF_0003, 1'b0, "mac_neg_acc"};

    bp_a = '{16'sd1, 16'sd3,  16'sd5,  16'sd7, -16'sd9,  16'sd11,  16'sd13};
    bp_b = '{16'sd1, 16'sd4, -16'sd6,  16'sd8,  16'sd10, 16'sd12, -16'sd14};

    rst_n           = 1'b0;
    bus_s.in_valid  = 1'b0;
    bus_s.op        = OP_ADD;
    bus_s.a         = '0;
    bus_s.b         = '0;
    bus_s.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus_s.out_valid, 0);
    check("rst_out",       bus_s.out,       0);
    check("rst_acc_ovf",   bus_s.acc_ovf,   0);
    check("rst_in_ready",  bus_s.in_ready,  1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge k, visible after edge k+1, delivered at edge k+2.
    issue(OP_ADD, 16'sh7FFF, 16'sh0001, 1'b1, 40'h00_0000_8000, 1'b0, "lat_add");
    check("lat_k_out_valid", bus_s.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_k1_out_valid", bus_s.out_valid, 1);
    check("lat_k1_out",       bus_s.out,       40'h00_0000_8000);
    drain("lat");

    for (int i = 0; i < 12; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp_out, vecs[i].exp_ovf, vecs[i].name);
    drain("table");

    // Back-pressure: downstream stalls three cycles while seven ops stream in.
    n0 = n_out;
    fork
      begin
        issue(OP_MACL, bp_a[0], bp_b[0], 1'b0, '0, 1'b0, "bp_macl");
        for (int i = 1; i < 7; i++)
          issue(OP_MAC, bp_a[i], bp_b[i], 1'b0, '0, 1'b0, "bp_mac");
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus_s.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_in_ready_low",  bus_s.in_ready,  0);
        check("bp_out_valid_held", bus_s.out_valid, 1);
        @(posedge clk);
        #1;
        bus_s.out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_out_count", ACC_W'(n_out - n0), 7);
    check("bp_final_acc", last_s, 40'hFF_FFFF_FF9B);

    // Accumulate full-scale squares until the 40-bit range is exceeded.
    issue(OP_MACL, 16'sh7FFF, 16'sh7FFF, 1'b0, '0, 1'b0, "sat_seed");
    for (int i = 0; i < 514; i++)
      issue(OP_MAC, 16'sh7FFF, 16'sh7FFF, 1'b0, '0, 1'b0, "sat_mac");
    drain("sat");
    check("sat_pinned_max", last_s,     40'h7F_FFFF_FFFF);
    check("sat_acc_ovf",    last_ovf_s, 1);
    check("wrap_negative",  last_w[ACC_W-1], 1);
    check("wrap_acc_ovf",   last_ovf_w, 1);
    issue(OP_MACL, 16'sd1, 16'sd1, 1'b1, 40'h00_0000_0001, 1'b0, "macl_clear");
    drain("clear");
    check("clear_out",      last_s,     40'h00_0000_0001);
    check("clear_ovf",      last_ovf_s, 0);
    check("clear_wrap_ovf", last_ovf_w, 0);

    // Reset with two MACs in flight: both are dropped and acc restarts at zero.
    issue(OP_MAC, 16'sd5, 16'sd5, 1'b0, '0, 1'b0, "rst_drop0");
    issue(OP_MAC, 16'sd6, 16'sd6, 1'b0, '0, 1'b0, "rst_drop1");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", bus_s.out_valid, 0);
    check("midrst_out",       bus_s.out,       0);
    check("midrst_in_ready",  bus_s.in_ready,  1);
    check("midrst_wrap_vld",  bus_w.out_valid, 0);
    exp_q.delete();
    m_acc_s = 0; m_acc_w = 0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
    issue(OP_MAC, 16'sd2, 16'sd2, 1'b1, 40'h00_0000_0004, 1'b0, "rst_mac");
    drain("rst");
    check("rst_mac_last", last_s, 40'h00_0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
